// File: rtl/cp0_regfile.sv
// CP0 status/cause/EPC register file: interrupt and exception arbitration,
// EPC capture on exception entry, mtc0 writes and mfc0 reads.
module cp0_regfile #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] ExcPC,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    // Only the implemented fields are stored; everything else reads as 0.
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_sel;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req = ie & ~exl & (|(HWInt & im));
    assign exc_req = ~exl & (ExcCodeIn != 5'd0);
    assign Req     = int_req | exc_req;
    assign ExcPC   = Req ? EXC_ENTRY : 32'h0;
    assign EPCOut  = epc;

    // A delay-slot victim restarts at the branch, one word earlier.
    assign pc_sel = BDIn ? (PC - 32'd4) : PC;

    assign sr_word    = {16'h0, im, 8'h0, exl, ie};
    assign cause_word = {bd, 15'h0, ip, 3'b000, exc_code, 2'b00};

    always_comb begin
        DOut = 32'h0;
        case (A1)
            ADDR_SR:    DOut = sr_word;
            ADDR_CAUSE: DOut = cause_word;
            ADDR_EPC:   DOut = epc;
            default:    DOut = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= 6'h0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'h0;
            exc_code <= 5'h0;
            epc      <= 32'h0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                // Exception entry wins over any mtc0 or eret in the same cycle.
                exl      <= 1'b1;
                bd       <= BDIn;
                exc_code <= int_req ? 5'd0 : ExcCodeIn;
                epc      <= {pc_sel[31:2], 2'b00};
            end else begin
                if (WE && A2 == ADDR_SR) begin
                    im  <= DIn[15:10];
                    exl <= DIn[1];
                    ie  <= DIn[0];
                end
                if (WE && A2 == ADDR_EPC) begin
                    epc <= DIn;
                end
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios plus randomized traffic against
// a word-level model of SR, Cause and EPC.
module tb_cp0_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic        req;
    logic [31:0] exc_pc;
    logic [31:0] epc_out;
    logic [31:0] dout;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0_regfile #(.EXC_ENTRY(32'h0000_4180)) dut (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .DIn(din), .WE(we),
        .PC(pc), .BDIn(bd_in), .ExcCodeIn(exc_code_in), .HWInt(hw_int),
        .EXLClr(exl_clr), .Req(req), .ExcPC(exc_pc), .EPCOut(epc_out),
        .DOut(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_int();
        return m_sr[0] & ~m_sr[1] & (|(hw_int & m_sr[15:10]));
    endfunction

    function automatic logic m_req();
        return m_int() | (~m_sr[1] & (exc_code_in != 5'd0));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] addr);
        case (addr)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        reset = 1'b0; a1 = 5'd0; a2 = 5'd0; din = 32'h0; we = 1'b0;
        pc = 32'h0000_3000; bd_in = 1'b0; exc_code_in = 5'd0;
        hw_int = 6'h0; exl_clr = 1'b0;
    endtask

    // One rising edge: the model takes the same inputs the DUT sees.
    task automatic tick();
        logic r, i;
        @(posedge clk);
        i = m_int();
        r = m_req();
        if (reset) begin
            m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
        end else begin
            m_cause[15:10] = hw_int;
            if (r) begin
                m_sr[1]       = 1'b1;
                m_cause[31]   = bd_in;
                m_cause[6:2]  = i ? 5'd0 : exc_code_in;
                m_epc         = bd_in ? pc - 32'd4 : pc;
                m_epc[1:0]    = 2'b00;
            end else begin
                if (we && a2 == 5'd12) m_sr = din & 32'h0000_FC03;
                if (we && a2 == 5'd14) m_epc = din;
                if (exl_clr) m_sr[1] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic write_sr(input logic [31:0] v);
        we = 1'b1; a2 = 5'd12; din = v;
        tick();
        we = 1'b0;
    endtask

    task automatic eret();
        exc_code_in = 5'd0; hw_int = 6'h0; exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; hw_int = 6'h3f;
        tick();
        tick();
        reset = 1'b0; hw_int = 6'h0;
        #1;
        if (req !== 1'b0) begin errors++; $display("FAIL reset_req actual=%0h required=0", req); end
        checks++;
        if (exc_pc !== 32'h0) begin errors++; $display("FAIL reset_excpc actual=%h required=0", exc_pc); end
        checks++;
        if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc actual=%h required=0", epc_out); end
        checks++;
        for (int a = 12; a <= 14; a++) begin
            a1 = 5'(a); #1;
            if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout a1=%0d actual=%h required=0", a, dout); end
            checks++;
        end
    endtask

    task automatic test_exception_entry();
        exc_code_in = 5'd4; pc = 32'h0000_3008; bd_in = 1'b0;
        #1;
        if (req !== 1'b1) begin errors++; $display("FAIL entry_req actual=%0h required=1", req); end
        checks++;
        if (exc_pc !== 32'h0000_4180) begin errors++; $display("FAIL entry_excpc actual=%h required=00004180", exc_pc); end
        checks++;
        tick();
        exc_code_in = 5'd0;
        a1 = 5'd13; #1;
        if (dout[6:2] !== 5'd4) begin errors++; $display("FAIL entry_exccode actual=%0d required=4", dout[6:2]); end
        checks++;
        if (epc_out !== 32'h0000_3008) begin errors++; $display("FAIL entry_epc actual=%h required=00003008", epc_out); end
        checks++;
        a1 = 5'd12; #1;
        if (dout[1] !== 1'b1) begin errors++; $display("FAIL entry_exl actual=%0h required=1", dout[1]); end
        checks++;
        eret();
        #1;
        if (dout[1] !== 1'b0) begin errors++; $display("FAIL eret_exl actual=%0h required=0", dout[1]); end
        checks++;
        a1 = 5'd13; #1;
        if (dout[6:2] !== 5'd4) begin errors++; $display("FAIL eret_keeps_cause actual=%0d required=4", dout[6:2]); end
        checks++;
    endtask

    task automatic test_delay_slot();
        exc_code_in = 5'd10; pc = 32'h0000_300C; bd_in = 1'b1;
        tick();
        exc_code_in = 5'd0; bd_in = 1'b0;
        a1 = 5'd13; #1;
        if (epc_out !== 32'h0000_3008) begin errors++; $display("FAIL bd_epc actual=%h required=00003008", epc_out); end
        checks++;
        if (dout[31] !== 1'b1) begin errors++; $display("FAIL bd_flag actual=%0h required=1", dout[31]); end
        checks++;
        if (dout[6:2] !== 5'd10) begin errors++; $display("FAIL bd_exccode actual=%0d required=10", dout[6:2]); end
        checks++;
        eret();
    endtask

    task automatic test_interrupt();
        write_sr(32'h0000_0401);
        a1 = 5'd12; #1;
        if (dout !== 32'h0000_0401) begin errors++; $display("FAIL int_sr_write actual=%h required=00000401", dout); end
        checks++;
        hw_int = 6'b000001; exc_code_in = 5'd0; #1;
        if (req !== 1'b1) begin errors++; $display("FAIL int_req actual=%0h required=1", req); end
        checks++;
        tick();
        a1 = 5'd13; #1;
        if (dout[6:2] !== 5'd0) begin errors++; $display("FAIL int_exccode actual=%0d required=0", dout[6:2]); end
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL int_masked_by_exl actual=%0h required=0", req); end
        checks++;
        eret();
        // IM cleared, IE set: no request but IP still tracks the line.
        write_sr(32'h0000_0001);
        hw_int = 6'b000001; #1;
        if (req !== 1'b0) begin errors++; $display("FAIL int_im0_req actual=%0h required=0", req); end
        checks++;
        tick();
        a1 = 5'd13; #1;
        if (dout[10] !== 1'b1) begin errors++; $display("FAIL int_ip_sample actual=%0h required=1", dout[10]); end
        checks++;
        hw_int = 6'h0;
        write_sr(32'h0000_0400);
        hw_int = 6'b000001; #1;
        if (req !== 1'b0) begin errors++; $display("FAIL int_ie0_req actual=%0h required=0", req); end
        checks++;
        hw_int = 6'h0;
    endtask

    task automatic test_int_beats_exc();
        write_sr(32'hFFFF_FFFF);
        a1 = 5'd12; #1;
        if (dout !== 32'h0000_FC03) begin errors++; $display("FAIL sr_hardwired actual=%h required=0000FC03", dout); end
        checks++;
        eret();
        hw_int = 6'b100000; exc_code_in = 5'd12; pc = 32'h0000_3100; #1;
        if (req !== 1'b1) begin errors++; $display("FAIL prio_req actual=%0h required=1", req); end
        checks++;
        tick();
        a1 = 5'd13; #1;
        if (dout[6:2] !== 5'd0) begin errors++; $display("FAIL prio_exccode actual=%0d required=0", dout[6:2]); end
        checks++;
        if (dout[15:10] !== 6'b100000) begin errors++; $display("FAIL prio_ip actual=%h required=20", dout[15:10]); end
        checks++;
        eret();
    endtask

    task automatic test_masking();
        write_sr(32'h0000_0401);
        exc_code_in = 5'd4; pc = 32'h0000_3010;
        tick();
        exc_code_in = 5'd4; hw_int = 6'b000001; pc = 32'h0000_3050; #1;
        if (req !== 1'b0) begin errors++; $display("FAIL mask_req actual=%0h required=0", req); end
        checks++;
        tick();
        tick();
        if (epc_out !== 32'h0000_3010) begin errors++; $display("FAIL mask_epc actual=%h required=00003010", epc_out); end
        checks++;
        eret();
    endtask

    task automatic test_collision();
        we = 1'b1; a2 = 5'd14; din = 32'h0000_1234;
        exc_code_in = 5'd4; pc = 32'h0000_3020;
        tick();
        we = 1'b0; exc_code_in = 5'd0;
        if (epc_out !== 32'h0000_3020) begin errors++; $display("FAIL collide_epc actual=%h required=00003020", epc_out); end
        checks++;
        eret();
        we = 1'b1; a2 = 5'd14; din = 32'h0000_1234;
        tick();
        if (epc_out !== 32'h0000_1234) begin errors++; $display("FAIL mtc0_epc actual=%h required=00001234", epc_out); end
        checks++;
        a2 = 5'd13; din = 32'hFFFF_FFFF;
        tick();
        we = 1'b0;
        a1 = 5'd13; #1;
        if (dout !== 32'h0000_0010) begin errors++; $display("FAIL cause_readonly actual=%h required=00000010", dout); end
        checks++;
    endtask

    task automatic test_reset_mid_handler();
        exc_code_in = 5'd4; pc = 32'h0000_3040;
        tick();
        exc_code_in = 5'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 12; a <= 14; a++) begin
            a1 = 5'(a); #1;
            if (dout !== 32'h0) begin errors++; $display("FAIL midreset_dout a1=%0d actual=%h required=0", a, dout); end
            checks++;
        end
        exc_code_in = 5'd4; #1;
        if (req !== 1'b1) begin errors++; $display("FAIL midreset_req actual=%0h required=1", req); end
        checks++;
        tick();
        exc_code_in = 5'd0;
        eret();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 39) == 0);
            a1          = ($urandom_range(0, 3) == 3) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(12, 14));
            a2          = ($urandom_range(0, 3) == 3) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(12, 14));
            din         = $urandom;
            we          = 1'($urandom_range(0, 1));
            pc          = $urandom;
            bd_in       = 1'($urandom_range(0, 1));
            exc_code_in = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw_int      = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'h0;
            exl_clr     = ($urandom_range(0, 3) == 0);
            #1;
            if (req !== m_req()) begin errors++; $display("FAIL rnd_req n=%0d actual=%0h required=%0h", n, req, m_req()); end
            checks++;
            if (exc_pc !== (m_req() ? 32'h0000_4180 : 32'h0)) begin errors++; $display("FAIL rnd_excpc n=%0d actual=%h", n, exc_pc); end
            checks++;
            if (epc_out !== m_epc) begin errors++; $display("FAIL rnd_epc n=%0d actual=%h required=%h", n, epc_out, m_epc); end
            checks++;
            if (dout !== m_read(a1)) begin errors++; $display("FAIL rnd_dout n=%0d a1=%0d actual=%h required=%h", n, a1, dout, m_read(a1)); end
            checks++;
            tick();
        end
        idle();
    endtask

    initial begin
        m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
        idle();
        test_reset();
        test_exception_entry();
        test_delay_slot();
        test_interrupt();
        test_int_beats_exc();
        test_masking();
        test_collision();
        test_reset_mid_handler();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 Parameter EXC_ENTRY, default 32'h0000_4180, exception handler entry address.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; takes effect on the rising edge of clk while high.
REQ-004 A1  input  5  read register number for mfc0.
REQ-005 A2  input  5  write register number for mtc0.
REQ-006 DIn  input  32  mtc0 write data.
REQ-007 WE  input  1  mtc0 write enable, from the M stage.
REQ-008 PC  input  32  PC of the instruction in the M stage, which is the macro PC.
REQ-009 BDIn  input  1  the M-stage instruction is in a branch delay slot.
REQ-010 ExcCodeIn  input  5  exception code carried down the pipeline; 0 means no exception.
REQ-011 HWInt  input  6  external hardware interrupt lines, level-sensitive.
REQ-012 EXLClr  input  1  eret in M stage; clears EXL.
REQ-013 Req  output  1  take-exception request; flushes the pipeline and redirects fetch.
REQ-014 ExcPC  output  32  EXC_ENTRY when Req=1, else 0.
REQ-015 EPCOut  output  32  current EPC register value, used as the eret target.
REQ-016 DOut  output  32  mfc0 read data selected by A1.

Function
REQ-017 Registers: SR (12), Cause (13), EPC (14).
- SR fields: IM = SR[15:10], EXL = SR[1], IE = SR[0]; all other SR bits are hardwired to 0.
- Cause fields: BD = [31], IP = [15:10], ExcCode = [6:2]; all other Cause bits are hardwired to 0.
REQ-018 IntReq = IE & ~EXL & |(HWInt & IM); ExcReq = ~EXL & (ExcCodeIn != 0); Req = IntReq | ExcReq. Req is combinational from the current state and inputs.
REQ-019 Interrupt priority: when IntReq=1, ExcCode is latched as 5'd0 regardless of ExcCodeIn; otherwise ExcCodeIn is latched.
REQ-020 On an edge with Req=1:
- EXL is set to 1.
- Cause.BD is set to BDIn.
- Cause.ExcCode is set per REQ-019.
- EPC is set to PC-4 if BDIn=1, else PC, with bits [1:0] forced to 0.
REQ-021 Cause.IP samples HWInt on every non-reset edge, independent of Req and EXL.
REQ-022 On an edge with WE=1 and Req=0:
- A2=12 writes the SR implemented bits from DIn.
- A2=14 writes EPC from DIn.
- A2=13 and all other addresses are ignored; Cause is not software-writable.
REQ-023 If Req=1 in the same cycle as WE=1, the mtc0 write is discarded and the exception update of REQ-020 applies.
REQ-024 On an edge with EXLClr=1 and Req=0, EXL is cleared; all other fields are unchanged. Req=1 with EXLClr=1 cannot occur for an exception already being handled, because EXL=1 forces Req=0.
REQ-025 While EXL=1, new interrupts and exceptions are masked:
- Req stays 0.
- EPC, BD and ExcCode hold their values.
- Only IP keeps tracking HWInt.
REQ-026 DOut returns SR, Cause or EPC for A1 = 12/13/14, and 0 for any other A1. It is combinational and reflects the pre-edge value, so there is no internal write-to-read bypass.
REQ-027 Latency:
- Req is visible in the same cycle as the cause.
- The register updates are visible in the next cycle.
- EPCOut follows the EPC register with no delay.

Reset
REQ-028 While reset=1 at an edge:
- SR, Cause and EPC all become 32'h0, so Req=0, EPCOut=0, ExcPC=0 and DOut=0 follow.
- Reset overrides Req, WE and EXLClr in the same cycle.
REQ-029 A reset asserted while EXL=1 (mid-handler) returns the block to EXL=0 with interrupts disabled (IE=0).

Verification
REQ-030 Exception entry and return:
- Stimulus: reset, then ExcCodeIn=5'd4, PC=32'h0000_3008, BDIn=0 for one cycle.
- Required: Req=1 and ExcPC=32'h0000_4180 that cycle; next cycle Cause[6:2]=4, EPC=32'h0000_3008, SR[1]=1.
- Follow-on: EXLClr=1 for one cycle, then SR[1]=0.
REQ-031 Delay-slot exception:
- Stimulus: ExcCodeIn=5'd10, PC=32'h0000_300C, BDIn=1.
- Required: EPC=32'h0000_3008 and Cause[31]=1.
REQ-032 Interrupt gating:
- Stimulus: mtc0 SR=32'h0000_0401, then HWInt=6'b000001.
- Required: Req=1 with Cause ExcCode=0.
- Variant: IM=0 or IE=0 leaves Req=0 while Cause[10]=1.
REQ-033 Interrupt beats exception: HWInt enabled and ExcCodeIn=5'd12 in the same cycle -> latched ExcCode=0.
REQ-034 Masking and write collision:
- Stimulus: with EXL=1, apply ExcCodeIn=5'd4 and HWInt active. Required: Req=0 and EPC unchanged.
- Stimulus: with EXL=0, apply WE=1, A2=14, DIn=32'h1234 together with ExcCodeIn=4. Required: EPC equals the PC, not 32'h1234.
REQ-035 Reset mid-handler: with EXL=1, pulse reset -> SR=Cause=EPC=0, and an immediately following ExcCodeIn=4 raises Req=1.
